// File: rtl/prime_stepper_pkg.sv
// Shared constants for the prime stepper: FSM state encodings and the first prime.
// Pure declarations; no logic, no latency, no flow control.
package prime_stepper_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_INC    = 3'd1;
    localparam state_t ST_CHECK  = 3'd2;
    localparam state_t ST_DIVIDE = 3'd3;
    localparam state_t ST_FOUND  = 3'd4;

    localparam int FIRST_PRIME = 2;

endpackage

// File: rtl/prime_stepper_remainder_unit.sv
// Restoring-division remainder, one quotient bit per cycle; done_o pulses WIDTH+1 cycles after start_i.
// No backpressure: start_i is honoured whenever it is high, abort_i drops any division in flight.
module remainder_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    // Partial remainder is always below the divisor, so one extra bit holds the shifted trial.
    assign w_trial = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_dvs};
    assign w_ge    = (w_trial >= {1'b0, r_dvs});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort_i) begin
                r_busy <= 1'b0;
            end else if (start_i) begin
                r_busy <= 1'b1;
                r_cnt  <= CW'(WIDTH);
                r_dvd  <= dividend_i;
                r_dvs  <= divisor_i;
                r_rem  <= '0;
            end else if (r_busy) begin
                r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_dvd <= r_dvd << 1;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign rem_o  = r_rem;
    assign done_o = r_done;

endmodule

// File: rtl/prime_stepper.sv
// Steps prime_o to the next prime by trial division up to sqrt(candidate); data-dependent latency.
// next_i is dropped while busy or overflowed; clear_i aborts and returns to 2 with no valid_o.
module prime_stepper
    import prime_stepper_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             next_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] prime_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic             overflow_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_prime;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_div;
    logic             r_ovf;

    logic [2*WIDTH-1:0] w_sq;
    logic               w_root_passed;
    logic               w_start;
    logic [WIDTH-1:0]   w_rem;
    logic               w_rem_done;

    // Full-width square so the sqrt bound never truncates near the top of the range.
    assign w_sq          = {{WIDTH{1'b0}}, r_div} * {{WIDTH{1'b0}}, r_div};
    assign w_root_passed = (w_sq > {{WIDTH{1'b0}}, r_cand});
    assign w_start       = (r_state == ST_CHECK) && !w_root_passed && !clear_i;

    remainder_unit #(.WIDTH(WIDTH)) u_rem (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (w_start),
        .abort_i    (clear_i),
        .dividend_i (r_cand),
        .divisor_i  (r_div),
        .rem_o      (w_rem),
        .done_o     (w_rem_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_prime <= WIDTH'(FIRST_PRIME);
            r_cand  <= '0;
            r_div   <= '0;
            r_ovf   <= 1'b0;
        end else if (clear_i) begin
            r_state <= ST_IDLE;
            r_prime <= WIDTH'(FIRST_PRIME);
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (next_i && !r_ovf) begin
                        r_cand  <= r_prime + ONE;
                        r_state <= ST_INC;
                    end
                end
                ST_INC: begin
                    if (r_cand == '0) begin
                        r_ovf   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_div   <= WIDTH'(2);
                        r_state <= ST_CHECK;
                    end
                end
                // prime_o is loaded on entry to FOUND so it is already stable while valid_o is high.
                ST_CHECK: begin
                    if (w_root_passed) begin
                        r_prime <= r_cand;
                        r_state <= ST_FOUND;
                    end else begin
                        r_state <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (w_rem_done) begin
                        if (w_rem == '0) begin
                            r_cand  <= r_cand + ONE;
                            r_state <= ST_INC;
                        end else begin
                            r_div   <= r_div + ONE;
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_FOUND: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign prime_o    = r_prime;
    assign busy_o     = (r_state != ST_IDLE);
    assign valid_o    = (r_state == ST_FOUND);
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_prime_stepper.sv
// Directed bench for prime_stepper: a 16-bit instance for sequencing/abort/reset, a 4-bit one for overflow.
module tb_prime_stepper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic drv_next, drv_clear, sel;

    logic        next16, clear16, busy16, valid16, ovf16;
    logic [15:0] prime16;
    logic        next4, clear4, busy4, valid4, ovf4;
    logic [3:0]  prime4;

    assign next16  = drv_next  & ~sel;
    assign clear16 = drv_clear & ~sel;
    assign next4   = drv_next  &  sel;
    assign clear4  = drv_clear &  sel;

    prime_stepper #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .next_i(next16), .clear_i(clear16),
        .prime_o(prime16), .busy_o(busy16), .valid_o(valid16), .overflow_o(ovf16)
    );

    prime_stepper #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .next_i(next4), .clear_i(clear4),
        .prime_o(prime4), .busy_o(busy4), .valid_o(valid4), .overflow_o(ovf4)
    );

    logic [15:0] cur_prime;
    logic        cur_busy, cur_valid, cur_ovf;

    always_comb begin
        cur_prime = sel ? {12'd0, prime4} : prime16;
        cur_busy  = sel ? busy4  : busy16;
        cur_valid = sel ? valid4 : valid16;
        cur_ovf   = sel ? ovf4   : ovf16;
    end

    int n_chk  = 0;
    int n_pass = 0;

    int seq[5] = '{3, 5, 7, 11, 13};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic pulse_next();
        drv_next = 1'b1;
        @(negedge clk);
        drv_next = 1'b0;
    endtask

    task automatic pulse_clear();
        drv_clear = 1'b1;
        @(negedge clk);
        drv_clear = 1'b0;
    endtask

    // Bounded observation window: counts valid pulses and records the prime shown with the last one.
    task automatic watch(input int cycles, output int nv, output logic [15:0] pv);
        nv = 0;
        pv = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (cur_valid) begin
                nv++;
                pv = cur_prime;
            end
        end
    endtask

    task automatic step(input string tag, input int exp);
        int          nv;
        logic [15:0] pv;
        pulse_next();
        watch(300, nv, pv);
        chk({tag, "_valids"}, nv, 1);
        chk({tag, "_prime"}, pv, exp);
        chk({tag, "_busy"}, cur_busy, 0);
    endtask

    initial begin
        int          nv;
        logic [15:0] pv;

        sel       = 1'b0;
        drv_next  = 1'b0;
        drv_clear = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_prime16", prime16, 2);
        chk("rst_busy16",  busy16,  0);
        chk("rst_valid16", valid16, 0);
        chk("rst_ovf16",   ovf16,   0);
        chk("rst_prime4",  prime4,  2);

        // Walk the first primes, one valid per request.
        for (int i = 0; i < 5; i++) step($sformatf("seq16_%0d", i), seq[i]);

        // Second request while busy is dropped.
        pulse_clear();
        chk("clr_prime16", prime16, 2);
        drv_next = 1'b1;
        @(negedge clk);
        drv_next = 1'b0;
        chk("dbl_busy", busy16, 1);
        pulse_next();
        watch(300, nv, pv);
        chk("dbl_valids", nv, 1);
        chk("dbl_prime", pv, 3);

        // Abort a search from 7 while the division is running.
        pulse_clear();
        for (int i = 0; i < 3; i++) step($sformatf("pre_abort_%0d", i), seq[i]);
        pulse_next();
        repeat (2) @(negedge clk);
        pulse_clear();
        chk("abort_prime", prime16, 2);
        chk("abort_busy",  busy16,  0);
        chk("abort_valid", valid16, 0);
        watch(100, nv, pv);
        chk("abort_no_valid", nv, 0);
        step("post_abort", 3);

        // 4-bit instance: 13 is the largest prime, next request overflows.
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) step($sformatf("seq4_%0d", i), seq[i]);
        pulse_next();
        watch(300, nv, pv);
        chk("ovf_no_valid", nv, 0);
        chk("ovf_flag",  cur_ovf,   1);
        chk("ovf_prime", cur_prime, 13);
        chk("ovf_busy",  cur_busy,  0);
        pulse_next();
        chk("ovf_ignored_busy", cur_busy, 0);
        watch(50, nv, pv);
        chk("ovf_ignored_valid", nv, 0);
        chk("ovf_ignored_prime", cur_prime, 13);
        pulse_clear();
        chk("ovf_clr_prime", cur_prime, 2);
        chk("ovf_clr_flag",  cur_ovf,   0);
        step("ovf_clr_next", 3);

        // Asynchronous reset while dividing 4 by 2.
        sel = 1'b0;
        @(negedge clk);
        pulse_clear();
        step("pre_rst", 3);
        pulse_next();
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy16, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_prime", prime16, 2);
        chk("arst_busy",  busy16,  0);
        chk("arst_valid", valid16, 0);
        chk("arst_ovf",   ovf16,   0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prime_stepper.md
PRIME_STEPPER -- requirements
Module: prime_stepper

Interface
REQ-001 Parameter: WIDTH, default 16, bit width of the prime value and of every candidate/divisor.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 Port: next_i  input  1  single-cycle request pulse (debounced button press) to advance to the next prime.
REQ-005 Port: clear_i  input  1  synchronous request to return to the first prime.
REQ-006 Port: prime_o  output  WIDTH  current prime, registered.
REQ-007 Port: busy_o  output  1  search in progress.
REQ-008 Port: valid_o  output  1  one-cycle pulse when prime_o has just been updated by a search.
REQ-009 Port: overflow_o  output  1  sticky flag: no larger prime fits in WIDTH bits.

Function
REQ-010 FSM states SHALL be IDLE, INC, CHECK, DIVIDE, FOUND.
REQ-011 IDLE: next_i=1 and overflow_o=0 -> cand <= prime_o+1, go INC; next_i while overflow_o=1 -> ignored.
REQ-012 busy_o SHALL be 1 in every state except IDLE, from the cycle after next_i until valid_o is asserted.
REQ-013 next_i while busy_o=1 SHALL be ignored (no queuing).
REQ-014 INC: if cand wrapped to 0 -> overflow_o <= 1, prime_o unchanged, back to IDLE, no valid_o; else div <= 2, go CHECK.
REQ-015 CHECK: if div*div > cand (full 2*WIDTH-bit product, no truncation) -> go FOUND; else start remainder unit on (cand, div), go DIVIDE.
REQ-016 DIVIDE: wait for remainder done; rem=0 -> cand <= cand+1, go INC; rem!=0 -> div <= div+1, go CHECK.
REQ-017 FOUND: prime_o <= cand, valid_o=1 for exactly this one cycle, go IDLE.
REQ-018 Search latency is data-dependent and bounded; any search SHALL terminate (FOUND or overflow) in fewer than 2^WIDTH*(WIDTH+3)*2^(WIDTH/2) cycles.
REQ-019 clear_i SHALL, from any state, load prime_o=2, clear overflow_o, drop busy_o, abort any running division, go IDLE next cycle, with no valid_o.
REQ-020 clear_i and next_i in the same cycle: clear_i wins, next_i discarded.
REQ-021 Arithmetic: cand, div unsigned WIDTH bits; cand+1 carry-out is the overflow indication; div never exceeds 2^(WIDTH/2)+1.

Reset
REQ-022 rst_n low SHALL asynchronously force: state IDLE, prime_o=2, busy_o=0, valid_o=0, overflow_o=0, cand=0, div=0, remainder unit idle.
REQ-023 Reset mid-search SHALL discard the search; after release the block accepts next_i on the first clock.

Structure
REQ-024 Shared package SHALL hold the FSM state enum and the constant FIRST_PRIME=2.
REQ-025 One sub-module, remainder_unit: restoring-division remainder, WIDTH-bit operands, start/done handshake, one quotient bit per cycle, done exactly WIDTH+1 cycles after start, same clk/rst_n, abort input driven by clear_i.

Verification
REQ-026 Reset release -> prime_o=2, busy_o=0, valid_o=0, overflow_o=0.
REQ-027 Five next_i pulses, each after valid_o -> prime_o sequence 3,5,7,11,13, one valid_o per pulse.
REQ-028 next_i pulsed twice, second while busy_o=1 -> single advance 2->3, exactly one valid_o.
REQ-029 WIDTH=4, advance to 13 then next_i -> overflow_o=1, prime_o stays 13, no valid_o; further next_i ignored; clear_i -> prime_o=2, overflow_o=0.
REQ-030 From 7, next_i then clear_i three cycles later (mid-search) -> prime_o=2, busy_o=0, no valid_o; next next_i -> 3.
REQ-031 rst_n asserted during DIVIDE -> outputs at reset values immediately, without a clock edge.
